// File: rtl/result_frame_accumulator.sv
// Frame accumulator for the 8-bit transform stream: per-frame saturating sum, max and min,
// published in registers with a one-cycle frame_done pulse.
module result_frame_accumulator #(
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = 12
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       cct_data,
    output logic             busy,
    output logic             frame_done,
    output logic [SUM_W-1:0] frame_sum,
    output logic [7:0]       frame_max,
    output logic [7:0]       frame_min,
    output logic             overflow,
    output logic [7:0]       sample_count
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

    localparam logic [SUM_W-1:0] SUM_MAX  = {SUM_W{1'b1}};
    localparam logic [7:0]       LAST_IDX = 8'(FRAME_LEN - 1);

    state_e           state_q;
    logic             busy_q, frame_done_q, overflow_q, run_ovf_q;
    logic [SUM_W-1:0] frame_sum_q, run_sum_q;
    logic [7:0]       frame_max_q, frame_min_q, run_max_q, run_min_q, count_q;

    logic [SUM_W:0]   sum_wide;
    logic [SUM_W-1:0] run_sum_d;
    logic             run_ovf_d;
    logic [7:0]       run_max_d, run_min_d;

    // One spare carry bit detects saturation; the carry is sticky via run_ovf.
    always_comb begin
        sum_wide  = {1'b0, run_sum_q} + {{(SUM_W-7){1'b0}}, cct_data};
        run_ovf_d = run_ovf_q | sum_wide[SUM_W];
        run_sum_d = sum_wide[SUM_W] ? SUM_MAX : sum_wide[SUM_W-1:0];
        run_max_d = (cct_data > run_max_q) ? cct_data : run_max_q;
        run_min_d = (cct_data < run_min_q) ? cct_data : run_min_q;
    end

    // NOTE: all state is plain flops updated with non-blocking assignments; clear is
    // synchronous and wins over every other input, aborting any frame in flight.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_sum_q  <= '0;
            frame_max_q  <= '0;
            frame_min_q  <= '0;
            overflow_q   <= 1'b0;
            count_q      <= '0;
            run_sum_q    <= '0;
            run_max_q    <= '0;
            run_min_q    <= 8'hFF;
            run_ovf_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= ACCUM;
                        busy_q    <= 1'b1;
                        run_sum_q <= '0;
                        run_max_q <= '0;
                        run_min_q <= 8'hFF;
                        run_ovf_q <= 1'b0;
                        count_q   <= '0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        run_sum_q <= run_sum_d;
                        run_ovf_q <= run_ovf_d;
                        run_max_q <= run_max_d;
                        run_min_q <= run_min_d;
                        if (count_q == LAST_IDX) begin
                            // Publish including the final sample, so results are ready with frame_done.
                            frame_sum_q  <= run_sum_d;
                            frame_max_q  <= run_max_d;
                            frame_min_q  <= run_min_d;
                            overflow_q   <= run_ovf_d;
                            count_q      <= '0;
                            state_q      <= DONE;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            count_q <= count_q + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign frame_sum    = frame_sum_q;
    assign frame_max    = frame_max_q;
    assign frame_min    = frame_min_q;
    assign overflow     = overflow_q;
    assign sample_count = count_q;

endmodule

// File: tb/tb_result_frame_accumulator.sv
// Directed bench for result_frame_accumulator: a default instance and a SUM_W=8 instance
// share the same stimulus; expected values are hand-computed constants.
module tb_result_frame_accumulator;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  cct_data = 8'h00;

    logic        busy_a, done_a, ovf_a;
    logic [11:0] sum_a;
    logic [7:0]  max_a, min_a, cnt_a;

    logic        busy_s, done_s, ovf_s;
    logic [7:0]  sum_s;
    logic [7:0]  max_s, min_s, cnt_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    result_frame_accumulator #(.FRAME_LEN(8), .SUM_W(12)) dut_a (
        .clk(clk), .clear(clear), .start(start), .in_valid(in_valid), .cct_data(cct_data),
        .busy(busy_a), .frame_done(done_a), .frame_sum(sum_a), .frame_max(max_a),
        .frame_min(min_a), .overflow(ovf_a), .sample_count(cnt_a)
    );

    result_frame_accumulator #(.FRAME_LEN(8), .SUM_W(8)) dut_s (
        .clk(clk), .clear(clear), .start(start), .in_valid(in_valid), .cct_data(cct_data),
        .busy(busy_s), .frame_done(done_s), .frame_sum(sum_s), .frame_max(max_s),
        .frame_min(min_s), .overflow(ovf_s), .sample_count(cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag, input int s_a, input int s_s, input int mx,
                                 input int mn, input int o_a, input int o_s);
        check({tag, " sum_a"}, 32'(sum_a), s_a);
        check({tag, " sum_s"}, 32'(sum_s), s_s);
        check({tag, " max_a"}, 32'(max_a), mx);
        check({tag, " min_a"}, 32'(min_a), mn);
        check({tag, " max_s"}, 32'(max_s), mx);
        check({tag, " min_s"}, 32'(min_s), mn);
        check({tag, " ovf_a"}, 32'(ovf_a), o_a);
        check({tag, " ovf_s"}, 32'(ovf_s), o_s);
    endtask

    // Start cycle also presents a junk valid sample that must be ignored.
    task automatic start_frame(input string tag);
        start = 1'b1; in_valid = 1'b1; cct_data = 8'h77;
        tick();
        start = 1'b0; in_valid = 1'b0;
        check({tag, " busy after start"}, 32'(busy_a), 1);
        check({tag, " count after start"}, 32'(cnt_a), 0);
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1; cct_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        check({tag, " done_a"}, 32'(done_a), 1);
        check({tag, " done_s"}, 32'(done_s), 1);
        check({tag, " busy in done"}, 32'(busy_a), 0);
        check({tag, " count in done"}, 32'(cnt_a), 0);
    endtask

    logic [7:0] vec [8];

    initial begin
        // Reset with start and in_valid asserted.
        start = 1'b1; in_valid = 1'b1; cct_data = 8'h55;
        tick(); tick();
        check("rst busy", 32'(busy_a), 0);
        check("rst done", 32'(done_a), 0);
        check("rst count", 32'(cnt_a), 0);
        check_results("rst", 0, 0, 0, 0, 0, 0);
        clear = 1'b0; start = 1'b0; in_valid = 1'b0;
        tick();

        // in_valid in IDLE is ignored.
        in_valid = 1'b1; cct_data = 8'h77;
        tick();
        in_valid = 1'b0;
        check("idle valid busy", 32'(busy_a), 0);
        check("idle valid count", 32'(cnt_a), 0);

        // Basic frame 1..8.
        start_frame("basic");
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("basic busy %0d", i), 32'(busy_a), 1);
            check($sformatf("basic count %0d", i), 32'(cnt_a), i - 1);
            check($sformatf("basic nodone %0d", i), 32'(done_a), 0);
            send(8'(i));
        end
        expect_done("basic");
        check_results("basic", 36, 36, 8, 1, 0, 0);
        tick();
        check("basic done pulse width", 32'(done_a), 0);
        check("basic idle busy", 32'(busy_a), 0);
        check_results("basic hold", 36, 36, 8, 1, 0, 0);

        // Gapped frame with start poked mid-frame and during DONE.
        start_frame("gap");
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("gap count %0d", i), 32'(cnt_a), i - 1);
            check($sformatf("gap busy v%0d", i), 32'(busy_a), 1);
            send(8'(i));
            if (i < 8) begin
                cct_data = 8'hAA;
                start = (i == 4);
                check($sformatf("gap busy g%0d", i), 32'(busy_a), 1);
                tick();
                start = 1'b0;
            end
        end
        expect_done("gap");
        check_results("gap", 36, 36, 8, 1, 0, 0);
        start = 1'b1; in_valid = 1'b1; cct_data = 8'h77;
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("gap start in done busy", 32'(busy_a), 0);
        check("gap start in done count", 32'(cnt_a), 0);
        check("gap start in done pulse", 32'(done_a), 0);
        tick();
        check("gap no restart", 32'(busy_a), 0);

        // Saturation: only the SUM_W=8 instance saturates.
        start_frame("sat");
        for (int i = 0; i < 8; i++) send(8'hFF);
        expect_done("sat");
        check_results("sat", 2040, 255, 255, 255, 0, 1);
        tick();

        // Abort after three samples.
        start_frame("abort");
        send(8'd5); send(8'd9); send(8'd2);
        check("abort count", 32'(cnt_a), 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort busy", 32'(busy_a), 0);
        check("abort done", 32'(done_a), 0);
        check("abort count cleared", 32'(cnt_a), 0);
        check_results("abort", 0, 0, 0, 0, 0, 0);
        tick();
        check("abort no late done", 32'(done_a), 0);
        start_frame("post");
        for (int i = 0; i < 8; i++) send(8'h10);
        expect_done("post");
        check_results("post", 128, 128, 16, 16, 0, 0);
        tick();

        // Max at the final sample.
        vec = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd200};
        start_frame("mix");
        for (int i = 0; i < 8; i++) send(vec[i]);
        expect_done("mix");
        check_results("mix", 221, 221, 200, 3, 0, 0);
        tick();
        check("mix done cleared", 32'(done_a), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/result_frame_accumulator.md
Name: result_frame_accumulator

Overview:
- Downstream stage of the 8-bit combinational input-transform circuit. It consumes that circuit's 8-bit result as a sample stream qualified by in_valid.
- Over a frame of FRAME_LEN accepted samples, it accumulates a saturating sum, maximum and minimum.
- It publishes the frame results in registers and pulses frame_done once per completed frame.

Parameters:
- FRAME_LEN, 8: accepted samples per frame; legal range 1..255.
- SUM_W, 12: width of the sum accumulator and frame_sum. Must be at least 8. The sum saturates at 2^SUM_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  reset; synchronous, active-high. Has priority over every other input.
- start  input  1  begin a new frame; sampled only in IDLE.
- in_valid  input  1  cct_data holds a sample this cycle; sampled only in ACCUM.
- cct_data  input  8  sample from the upstream transform stage, unsigned.
- busy  output  1  high while in ACCUM.
- frame_done  output  1  one-cycle pulse; frame results are valid and updated.
- frame_sum  output  SUM_W  saturating unsigned sum of the last completed frame.
- frame_max  output  8  largest sample of the last completed frame.
- frame_min  output  8  smallest sample of the last completed frame.
- overflow  output  1  last completed frame's sum saturated.
- sample_count  output  8  samples accepted so far in the current frame.

Behaviour:
- Reset (clear=1 at a clock edge):
  - state goes to IDLE.
  - busy, frame_done, frame_sum, frame_max, frame_min, overflow and sample_count all go to 0.
  - Internal running registers go to 0, except run_min, which goes to 8'hFF.
- clear during ACCUM or DONE aborts the frame. No frame_done is produced and published results are zeroed.
- States:
  - IDLE:
    - busy=0.
    - start=1 (with clear=0) -> ACCUM at the next edge. At that edge run_sum=0, run_max=0, run_min=8'hFF, run_ovf=0, sample_count=0.
    - in_valid is ignored in IDLE, including in the cycle start is high.
  - ACCUM:
    - busy=1 and start is ignored.
    - On each edge with in_valid=1, the sample is accepted:
      - run_sum becomes min(run_sum+cct_data, 2^SUM_W-1). Compute in SUM_W+1 bits.
      - run_ovf is set (sticky) if the true sum exceeded 2^SUM_W-1.
      - run_max becomes max(run_max, cct_data).
      - run_min becomes min(run_min, cct_data).
      - sample_count increments by 1.
    - in_valid=0: all running state holds; no timeout.
    - Final sample (accepted while sample_count==FRAME_LEN-1), at that edge:
      - frame_sum, frame_max, frame_min and overflow load the values including the final sample.
      - sample_count returns to 0.
      - state -> DONE.
  - DONE:
    - Lasts exactly one cycle. frame_done=1, busy=0.
    - start and in_valid are ignored.
    - Unconditional transition to IDLE.
- Latency: frame_done is high in the clock cycle immediately after the edge that accepted the final sample.
- frame_sum, frame_max, frame_min and overflow:
  - are valid whenever frame_done=1;
  - hold their values until the next frame completes or clear is applied.
- frame_done is registered, not combinational.
- FRAME_LEN=1: a single accepted sample goes to DONE, giving frame_max = frame_min = the sample.
- Saturation: once saturated, frame_sum stays at 2^SUM_W-1 for the rest of the frame.
- Width rules: cct_data is zero-extended to SUM_W+1 bits before the add. Max and min compare as unsigned 8-bit values.
- Minimum frame time: FRAME_LEN+2 cycles from start to the next cycle in which start is accepted (ACCUM, DONE, IDLE).

Test Plan:
- Reset: clear=1 for 2 cycles with start=1 and in_valid=1 -> busy=0, frame_done=0, all result outputs 0, sample_count=0.
- Basic frame (defaults): start pulse, then samples 1,2,…,8 on consecutive cycles -> busy=1 throughout ACCUM. One cycle after the 8th edge: frame_done=1 for exactly 1 cycle, frame_sum=36, frame_max=8, frame_min=1, overflow=0.
- Gapped input: same 8 samples with in_valid toggling 1/0 each cycle, cct_data=8'hAA during gaps -> identical results. busy stays 1 for 15 cycles, sample_count steps 0..7.
- Saturation (SUM_W=8): eight samples of 8'hFF -> frame_sum=8'hFF, overflow=1, frame_max=8'hFF, frame_min=8'hFF.
- Abort: start, 3 samples (5,9,2), then clear=1 for 1 cycle -> IDLE, no frame_done, all results 0. A new frame of eight 8'h10 samples -> frame_sum=128, min=max=8'h10.
- Ignored inputs:
  - in_valid=1 with cct_data=8'h77 during IDLE and in the start cycle -> not counted.
  - start asserted mid-ACCUM and during DONE -> no restart.
  - Frame of samples 3,3,3,3,3,3,3,200 -> frame_sum=221, max=200, min=3.
